// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one byte-serial transmitter among NUM_REQ byte producers. A
// round-robin pointer picks the next requester. Its byte is latched into
// tx_data, and tx_start and ack[winner] are pulsed for one cycle. The arbiter
// then follows the transmitter's busy flag until the frame has been shifted
// out.
//
// Multi-byte packets can hold the arbiter: a byte accepted with req_last=0
// locks arbitration to its owner until that owner's last byte is accepted.
// If tx_busy never rises after a start, a timeout pulses tx_err, drops the
// lock and returns to IDLE.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   req        per-requester byte-pending level
//   req_data   byte of requester i on bits [8i+7:8i]
//   req_last   1: the presented byte ends the requester's packet
//   ack        one-cycle pulse, requester's byte consumed (one-hot or zero)
//   owner      index of the most recent winner
//   locked     arbitration currently locked to owner
//   arb_busy   arbiter is not idle
//   tx_err     one-cycle pulse on busy timeout
//   tx_start   start strobe to the transmitter
//   tx_data    registered byte to the transmitter
//   tx_busy    busy flag from the transmitter
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     ack,
    output logic [2:0]             owner,
    output logic                   locked,
    output logic                   arb_busy,
    output logic                   tx_err,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_e;

    localparam logic [7:0] TIMEOUT_LAST = 8'(BUSY_TIMEOUT - 1);
    // Pointer starts at the highest index so requester 0 is scanned first.
    localparam logic [2:0] LAST_RESET   = 3'(NUM_REQ - 1);

    state_e     state_q, state_d;
    logic [2:0] owner_q, owner_d;
    logic [2:0] last_q,  last_d;
    logic       locked_q, locked_d;
    logic [7:0] data_q,  data_d;
    logic [7:0] cnt_q,   cnt_d;

    logic [7:0] req_ext_s;
    logic [7:0] last_ext_s;
    logic [7:0] elig_s;
    logic [3:0] scan_raw_s;
    logic [2:0] scan_idx_s;
    logic [2:0] win_s;
    logic       found_s;
    logic [7:0] win_byte_s;
    logic       win_last_s;

    // Eligibility mask: a held lock narrows the candidates to the owner only.
    always_comb begin
        req_ext_s  = 8'(req);
        last_ext_s = 8'(req_last);
        if (locked_q) begin
            elig_s = req_ext_s & (8'b0000_0001 << owner_q);
        end else begin
            elig_s = req_ext_s;
        end
    end

    // Round-robin scan. Iterating from the farthest offset down to the
    // nearest one lets the nearest eligible index overwrite earlier hits,
    // so the result is the first eligible index after last_q.
    always_comb begin
        found_s    = 1'b0;
        win_s      = last_q;
        scan_raw_s = 4'd0;
        scan_idx_s = 3'd0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            scan_raw_s = {1'b0, last_q} + 4'(k);
            scan_idx_s = (scan_raw_s >= 4'(NUM_REQ)) ? 3'(scan_raw_s - 4'(NUM_REQ))
                                                     : scan_raw_s[2:0];
            win_s      = elig_s[scan_idx_s] ? scan_idx_s : win_s;
            found_s    = found_s | elig_s[scan_idx_s];
        end
    end

    // Byte and packet-end flag presented by the selected requester.
    always_comb begin
        win_byte_s = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_byte_s = (win_s == 3'(i)) ? req_data[8*i +: 8] : win_byte_s;
        end
        win_last_s = last_ext_s[win_s];
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            owner_q  <= 3'd0;
            last_q   <= LAST_RESET;
            locked_q <= 1'b0;
            data_q   <= 8'h00;
            cnt_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            locked_q <= locked_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        locked_d = locked_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                // The tx_busy guard also covers a frame left running
                // across a reset of the arbiter.
                if (!tx_busy && found_s) begin
                    state_d  = S_LAUNCH;
                    data_d   = win_byte_s;
                    owner_d  = win_s;
                    last_d   = win_s;
                    locked_d = ~win_last_s;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_BUSY;
                cnt_d   = 8'h00;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d  = S_IDLE;
                    locked_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the state register.
    always_comb begin
        tx_start = 1'b0;
        tx_err   = 1'b0;
        ack      = '0;
        arb_busy = (state_q != S_IDLE);
        case (state_q)
            S_LAUNCH: begin
                tx_start = 1'b1;
                ack      = NUM_REQ'(8'b0000_0001 << owner_q);
            end
            S_WAIT_BUSY: begin
                tx_err = !tx_busy && (cnt_q == TIMEOUT_LAST);
            end
            default: begin
                tx_start = 1'b0;
            end
        endcase
    end

    assign owner   = owner_q;
    assign locked  = locked_q;
    assign tx_data = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int TO    = 15;
    localparam int FRAME = 10;
    localparam int MAXB  = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req = '0;
    logic [8*N-1:0]   req_data = '0;
    logic [N-1:0]     req_last = '0;
    logic             tx_busy = 1'b0;
    logic [N-1:0]     ack;
    logic [2:0]       owner;
    logic             locked;
    logic             arb_busy;
    logic             tx_err;
    logic             tx_start;
    logic [7:0]       tx_data;

    int n_checks = 0;
    int n_fail   = 0;

    // producer contents
    logic [7:0] pd [N][MAXB];
    bit         pl [N][MAXB];
    int         plen [N];
    int         pidx [N];

    // observations
    logic [7:0] sent_q [$];
    int         own_q  [$];
    bit         lock_q [$];
    // reference expectations
    logic [7:0] exp_d [$];
    int         exp_o [$];
    bit         exp_l [$];

    int bad_ack = 0;
    int overlap = 0;
    int busy_left = 0;
    bit xmit_en = 1'b1;
    bit timed_out = 1'b0;

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .ack      (ack),
        .owner    (owner),
        .locked   (locked),
        .arb_busy (arb_busy),
        .tx_err   (tx_err),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    // transmitter model: busy for FRAME cycles starting the cycle after a start
    always @(posedge clk) begin
        if (tx_start && tx_busy) overlap <= overlap + 1;
        if (tx_start && xmit_en && !tx_busy) begin
            sent_q.push_back(tx_data);
            busy_left <= FRAME;
            tx_busy   <= 1'b1;
        end else if (busy_left > 1) begin
            busy_left <= busy_left - 1;
        end else begin
            busy_left <= 0;
            tx_busy   <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1);
    end

    task automatic clear_prod();
        for (int i = 0; i < N; i++) begin
            plen[i] = 0;
            pidx[i] = 0;
        end
    endtask

    task automatic present();
        for (int i = 0; i < N; i++) begin
            if (pidx[i] < plen[i]) begin
                req[i]            = 1'b1;
                req_data[8*i +: 8] = pd[i][pidx[i]];
                req_last[i]       = pl[i][pidx[i]];
            end else begin
                req[i]            = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
    endtask

    function automatic bit all_done();
        bit d = 1'b1;
        for (int i = 0; i < N; i++) if (pidx[i] < plen[i]) d = 1'b0;
        return d;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_prod();
        present();
        sent_q.delete();
        own_q.delete();
        lock_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit expired);
        int k = 0;
        expired = 1'b0;
        while (arb_busy !== 1'b0 || tx_busy !== 1'b0) begin
            if (k >= budget) begin
                expired = 1'b1;
                break;
            end
            @(negedge clk);
            k++;
        end
    endtask

    // producers react to ack by presenting their next byte or dropping req
    task automatic run_traffic(input int budget);
        int cyc = 0;
        bad_ack   = 0;
        timed_out = 1'b0;
        present();
        while (!(all_done() && arb_busy === 1'b0 && tx_busy === 1'b0)) begin
            if (cyc >= budget) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
            if (ack !== '0) begin
                if (!$onehot(ack) || tx_start !== 1'b1 || ack !== (4'b0001 << owner)) bad_ack++;
                own_q.push_back(int'(owner));
                lock_q.push_back(locked);
                for (int i = 0; i < N; i++) if (ack[i]) pidx[i]++;
                present();
            end else if (tx_start !== 1'b0) begin
                bad_ack++;
            end
        end
    endtask

    // transaction-level reference: ordering from round-robin and lock rules
    task automatic model_expected();
        int idx [N];
        int last_w = N - 1;
        int own_w  = 0;
        bit lk     = 1'b0;
        int w;
        int j;
        exp_d.delete();
        exp_o.delete();
        exp_l.delete();
        for (int i = 0; i < N; i++) idx[i] = 0;
        for (int step = 0; step < N * MAXB; step++) begin
            w = -1;
            if (lk) begin
                if (idx[own_w] < plen[own_w]) w = own_w;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    j = (last_w + k) % N;
                    if (w < 0 && idx[j] < plen[j]) w = j;
                end
            end
            if (w < 0) break;
            exp_d.push_back(pd[w][idx[w]]);
            exp_o.push_back(w);
            lk = !pl[w][idx[w]];
            exp_l.push_back(lk);
            idx[w]++;
            own_w  = w;
            last_w = w;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({ack, tx_start, tx_err, locked, arb_busy} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: ack=%b start=%b err=%b locked=%b busy=%b, required all 0",
                     ack, tx_start, tx_err, locked, arb_busy);
        end
        n_checks++;
        if (tx_data !== 8'h00 || owner !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_data: tx_data=%h owner=%0d, required 00 and 0", tx_data, owner);
        end
    endtask

    task automatic test_single();
        int k = 0;
        do_reset();
        pd[0][0] = 8'h55; pl[0][0] = 1'b1; plen[0] = 1;
        present();
        @(negedge clk);
        n_checks++;
        if (ack !== 4'b0001 || tx_start !== 1'b1) begin
            n_fail++;
            $display("FAIL single_launch: ack=%b start=%b, required 0001 and 1", ack, tx_start);
        end
        n_checks++;
        if (tx_data !== 8'h55 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL single_data: tx_data=%h locked=%b, required 55 and 0", tx_data, locked);
        end
        pidx[0] = 1;
        present();
        while (tx_busy !== 1'b1 && k < 60) begin @(negedge clk); k++; end
        while (tx_busy === 1'b1 && k < 60) begin @(negedge clk); k++; end
        n_checks++;
        if (k >= 60 || arb_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_done_wait: cycles=%0d arb_busy=%b, required <60 and 1", k, arb_busy);
        end
        @(negedge clk);
        n_checks++;
        if (arb_busy !== 1'b0 || sent_q.size() != 1) begin
            n_fail++;
            $display("FAIL single_idle: arb_busy=%b frames=%0d, required 0 and 1", arb_busy, sent_q.size());
        end else begin
            n_checks++;
            if (sent_q[0] !== 8'h55) begin
                n_fail++;
                $display("FAIL single_byte: sent=%h, required 55", sent_q[0]);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int b = 0; b < 3; b++) begin
                pd[i][b] = 8'hA0 + 8'(i);
                pl[i][b] = 1'b1;
            end
            plen[i] = 3;
        end
        model_expected();
        run_traffic(2000);
        n_checks++;
        if (timed_out || bad_ack != 0 || sent_q.size() != exp_d.size() || own_q.size() != exp_o.size()) begin
            n_fail++;
            $display("FAIL rr_shape: timeout=%0d bad_ack=%0d frames=%0d acks=%0d, required 0 0 %0d %0d",
                     timed_out, bad_ack, sent_q.size(), own_q.size(), exp_d.size(), exp_o.size());
        end else begin
            for (int j = 0; j < exp_d.size(); j++) begin
                n_checks++;
                if (sent_q[j] !== exp_d[j] || own_q[j] != exp_o[j] || lock_q[j] !== exp_l[j]) begin
                    n_fail++;
                    $display("FAIL rr_item%0d: byte=%h owner=%0d locked=%b, required %h %0d %b",
                             j, sent_q[j], own_q[j], lock_q[j], exp_d[j], exp_o[j], exp_l[j]);
                end
            end
        end
    endtask

    task automatic test_packet_lock();
        do_reset();
        pd[0][0] = 8'h10; pl[0][0] = 1'b0;
        pd[0][1] = 8'h11; pl[0][1] = 1'b0;
        pd[0][2] = 8'h12; pl[0][2] = 1'b1;
        plen[0] = 3;
        pd[2][0] = 8'h22; pl[2][0] = 1'b1;
        plen[2] = 1;
        model_expected();
        run_traffic(1000);
        n_checks++;
        if (timed_out || bad_ack != 0 || sent_q.size() != exp_d.size() || own_q.size() != exp_o.size()) begin
            n_fail++;
            $display("FAIL lock_shape: timeout=%0d bad_ack=%0d frames=%0d acks=%0d, required 0 0 %0d %0d",
                     timed_out, bad_ack, sent_q.size(), own_q.size(), exp_d.size(), exp_o.size());
        end else begin
            for (int j = 0; j < exp_d.size(); j++) begin
                n_checks++;
                if (sent_q[j] !== exp_d[j] || own_q[j] != exp_o[j] || lock_q[j] !== exp_l[j]) begin
                    n_fail++;
                    $display("FAIL lock_item%0d: byte=%h owner=%0d locked=%b, required %h %0d %b",
                             j, sent_q[j], own_q[j], lock_q[j], exp_d[j], exp_o[j], exp_l[j]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pd[1][0] = 8'hB1; pl[1][0] = 1'b1;
        pd[1][1] = 8'hB2; pl[1][1] = 1'b1;
        plen[1] = 2;
        run_traffic(1000);
        n_checks++;
        if (timed_out || bad_ack != 0 || sent_q.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_shape: timeout=%0d bad_ack=%0d frames=%0d, required 0 0 2",
                     timed_out, bad_ack, sent_q.size());
        end else begin
            n_checks++;
            if (sent_q[0] !== 8'hB1 || sent_q[1] !== 8'hB2) begin
                n_fail++;
                $display("FAIL b2b_bytes: sent=%h %h, required B1 B2", sent_q[0], sent_q[1]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            do_reset();
            for (int i = 0; i < N; i++) begin
                plen[i] = $urandom_range(0, 5);
                for (int b = 0; b < plen[i]; b++) begin
                    pd[i][b] = 8'($urandom);
                    pl[i][b] = ($urandom_range(0, 2) == 0);
                end
                if (plen[i] > 0) pl[i][plen[i] - 1] = 1'b1;
            end
            model_expected();
            run_traffic(3000);
            n_checks++;
            if (timed_out || bad_ack != 0 || sent_q.size() != exp_d.size() || own_q.size() != exp_o.size()) begin
                n_fail++;
                $display("FAIL rand%0d_shape: timeout=%0d bad_ack=%0d frames=%0d acks=%0d, required 0 0 %0d %0d",
                         it, timed_out, bad_ack, sent_q.size(), own_q.size(), exp_d.size(), exp_o.size());
            end else begin
                for (int j = 0; j < exp_d.size(); j++) begin
                    n_checks++;
                    if (sent_q[j] !== exp_d[j] || own_q[j] != exp_o[j] || lock_q[j] !== exp_l[j]) begin
                        n_fail++;
                        $display("FAIL rand%0d_item%0d: byte=%h owner=%0d locked=%b, required %h %0d %b",
                                 it, j, sent_q[j], own_q[j], lock_q[j], exp_d[j], exp_o[j], exp_l[j]);
                    end
                end
            end
        end
        n_checks++;
        if (overlap != 0) begin
            n_fail++;
            $display("FAIL start_while_busy: count=%0d, required 0", overlap);
        end
    endtask

    task automatic test_timeout();
        int k = 0;
        do_reset();
        xmit_en = 1'b0;
        pd[0][0] = 8'h77; pl[0][0] = 1'b0; plen[0] = 1;
        present();
        @(negedge clk);
        n_checks++;
        if (tx_start !== 1'b1 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL to_launch: start=%b locked=%b, required 1 and 1", tx_start, locked);
        end
        pidx[0] = 1;
        present();
        do begin
            @(negedge clk);
            k++;
        end while (tx_err !== 1'b1 && k < 40);
        n_checks++;
        if (k != TO) begin
            n_fail++;
            $display("FAIL to_latency: tx_err after %0d cycles, required %0d", k, TO);
        end
        @(negedge clk);
        n_checks++;
        if (tx_err !== 1'b0 || locked !== 1'b0 || arb_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL to_after: err=%b locked=%b busy=%b, required 0 0 0", tx_err, locked, arb_busy);
        end
        xmit_en = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        int k = 0;
        int early = 0;
        bit expired;
        do_reset();
        pd[1][0] = 8'h3C; pl[1][0] = 1'b0; plen[1] = 1;
        present();
        @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx_busy !== 1'b1 || arb_busy !== 1'b1 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL rmf_pre: tx_busy=%b arb_busy=%b locked=%b, required 1 1 1", tx_busy, arb_busy, locked);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({ack, tx_start, tx_err, locked, arb_busy} !== 8'h00 || tx_data !== 8'h00 || owner !== 3'd0) begin
            n_fail++;
            $display("FAIL rmf_reset: ack=%b start=%b err=%b locked=%b busy=%b data=%h owner=%0d, required all 0",
                     ack, tx_start, tx_err, locked, arb_busy, tx_data, owner);
        end
        while (tx_busy === 1'b1 && k < 60) begin
            if (tx_start !== 1'b0) early++;
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (early != 0 || k >= 60) begin
            n_fail++;
            $display("FAIL rmf_guard: starts while busy=%0d wait=%0d, required 0 and <60", early, k);
        end
        k = 0;
        while (tx_start !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k != 1 || tx_data !== 8'h3C || ack !== 4'b0010) begin
            n_fail++;
            $display("FAIL rmf_relaunch: delay=%0d data=%h ack=%b, required 1 3C 0010", k, tx_data, ack);
        end
        pidx[1] = 1;
        present();
        wait_idle(100, expired);
        n_checks++;
        if (expired || overlap != 0) begin
            n_fail++;
            $display("FAIL rmf_end: idle_expired=%b overlap=%0d, required 0 0", expired, overlap);
        end
    endtask

    initial begin
        clear_prod();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_packet_lock();
        test_back_to_back();
        test_timeout();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
